// File: rtl/imem_pkg.sv
// Shared types, opcodes and immediate decode for the
// multi-core instruction memory.
package imem_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    SERVE,
    LOAD
  } imem_state_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  function automatic imm_type_e imm_type_of(
    input logic [6:0] op
  );
    imm_type_e t;
    unique case (op)
      OP_LOAD,
      OP_IMM,
      OP_JALR,
      OP_SYSTEM: t = IMM_I;
      OP_STORE:  t = IMM_S;
      OP_BRANCH: t = IMM_B;
      OP_LUI,
      OP_AUIPC:  t = IMM_U;
      OP_JAL:    t = IMM_J;
      default:   t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] decode_imm(
    input logic [31:0] inst
  );
    logic [31:0] imm;
    unique case (imm_type_of(inst[6:0]))
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25],
                    inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31],
                    inst[19:12], inst[20],
                    inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/imem_mc_rr_arbiter.sv
// Round-robin arbiter; the pointer moves past the winner
// only when the caller signals that the grant was taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/imem_mc.sv
// Multi-core instruction memory: shared word array, load mode,
// round-robin fetch and per-channel registered decode.
module imem_mc
  import imem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 11,
  parameter int XLEN      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_mode,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [ADDR_W-1:0]           load_addr,
  input  logic [XLEN-1:0]             load_data,
  input  logic [NUM_CORES-1:0]        fetch_req,
  input  logic [NUM_CORES*ADDR_W-1:0] fetch_addr,
  output logic [NUM_CORES-1:0]        fetch_gnt,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [NUM_CORES-1:0]        rsp_err,
  output logic [NUM_CORES*XLEN-1:0]   rsp_inst,
  output logic [NUM_CORES*5-1:0]      rsp_rs1,
  output logic [NUM_CORES*5-1:0]      rsp_rs2,
  output logic [NUM_CORES*5-1:0]      rsp_rd,
  output logic [NUM_CORES*XLEN-1:0]   rsp_imm
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  imem_state_e state_q, state_d;

  logic [XLEN-1:0] mem [DEPTH];

  logic                 serve_en;
  logic [NUM_CORES-1:0] req_m;
  logic [ADDR_W-1:0]    raddr;
  logic                 mis;
  logic [XLEN-1:0]      rinst;
  logic [XLEN-1:0]      rimm;
  logic [1:0]           unused_addr;

  logic [NUM_CORES-1:0] vld_q, err_q;
  logic [XLEN-1:0]      inst_q [NUM_CORES];
  logic [XLEN-1:0]      imm_q  [NUM_CORES];
  logic [4:0]           rs1_q  [NUM_CORES];
  logic [4:0]           rs2_q  [NUM_CORES];
  logic [4:0]           rd_q   [NUM_CORES];

  assign unused_addr = load_addr[1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SERVE: if (load_mode)  state_d = LOAD;
      LOAD:  if (!load_mode) state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SERVE;
    else        state_q <= state_d;
  end

  // Load wins over fetch in the cycle load_mode is first seen.
  assign serve_en   = rst_n && (state_q == SERVE)
                      && !load_mode;
  assign load_ready = (state_q == LOAD);
  assign req_m      = fetch_req & {NUM_CORES{serve_en}};

  rr_arbiter #(
    .N(NUM_CORES)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_m),
    .advance(serve_en),
    .gnt    (fetch_gnt)
  );

  always_ff @(posedge clk) begin
    if (load_valid && load_ready)
      mem[load_addr[ADDR_W-1:2]] <= load_data;
  end

  always_comb begin
    raddr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (fetch_gnt[i])
        raddr = fetch_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign mis   = |raddr[1:0];
  assign rinst = mis ? NOP : mem[raddr[ADDR_W-1:2]];
  assign rimm  = decode_imm(rinst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        inst_q[i] <= '0;
        imm_q[i]  <= '0;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      vld_q <= fetch_gnt;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (fetch_gnt[i]) begin
          err_q[i]  <= mis;
          inst_q[i] <= rinst;
          imm_q[i]  <= rimm;
          rs1_q[i]  <= rinst[19:15];
          rs2_q[i]  <= rinst[24:20];
          rd_q[i]   <= rinst[11:7];
        end
      end
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
    assign rsp_inst[g*XLEN +: XLEN] = inst_q[g];
    assign rsp_imm[g*XLEN +: XLEN]  = imm_q[g];
    assign rsp_rs1[g*5 +: 5]        = rs1_q[g];
    assign rsp_rs2[g*5 +: 5]        = rs2_q[g];
    assign rsp_rd[g*5 +: 5]         = rd_q[g];
  end

endmodule

// File: doc/imem_mc.md
Name: imem_mc

Overview:
Parametrised, multi-core instruction memory; successor to the single-port imem.
- One word-organised RV32 instruction array shared by NUM_CORES fetch channels through a round-robin arbiter.
- Separate load (preload) mode with a valid/ready write port.
- Per-channel registered response: raw instruction plus decoded rs1/rs2/rd and sign-extended immediate, feeding each core's decode stage.

Parameters:
- NUM_CORES, 4, number of fetch channels (1..8)
- ADDR_W, 11, byte-address width; DEPTH = 2**(ADDR_W-2) words
- XLEN, 32, instruction/immediate width (fixed 32, parametrised for package use)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_mode  in  1  high requests load mode; fetch is blocked while in LOAD
- load_valid  in  1  write-word strobe
- load_ready  out  1  array accepts writes (high only in LOAD)
- load_addr  in  ADDR_W  byte address of the word written; bits [1:0] ignored
- load_data  in  XLEN  instruction word
- fetch_req  in  NUM_CORES  per-channel request; held until granted
- fetch_addr  in  NUM_CORES*ADDR_W  per-channel byte address; channel i at [i*ADDR_W +: ADDR_W]
- fetch_gnt  out  NUM_CORES  one-hot grant, combinational, same cycle as request
- rsp_valid  out  NUM_CORES  one-cycle pulse, cycle after grant
- rsp_err  out  NUM_CORES  misaligned fetch flag, qualified by rsp_valid
- rsp_inst  out  NUM_CORES*XLEN  instruction word
- rsp_rs1, rsp_rs2, rsp_rd  out  NUM_CORES*5 each  instruction bits [19:15], [24:20], [11:7]
- rsp_imm  out  NUM_CORES*XLEN  sign-extended immediate

Behaviour:
- Reset: state SERVE, arbiter pointer 0, load_ready 0. All rsp_* outputs and fetch_gnt are 0. Array contents are not reset and survive rst_n.
- FSM SERVE:
  - If load_mode=1, go to LOAD next cycle; grant nothing in that cycle (load has priority over simultaneous requests).
  - Otherwise grant at most one requester per cycle.
- FSM LOAD:
  - load_ready=1; on load_valid&&load_ready, write array[load_addr[ADDR_W-1:2]] = load_data.
  - fetch_gnt stays 0 and requests wait.
  - load_mode=0 returns to SERVE next cycle; load_ready falls in that same cycle.
- Arbitration:
  - Round-robin starting at the pointer. After a grant to channel g, pointer = (g+1) mod NUM_CORES.
  - Pointer is unchanged when no grant is issued.
  - A single requester is granted every cycle (back-to-back, no bubble).
- Fetch latency: grant in cycle N; in cycle N+1, rsp_valid[g]=1 for exactly one cycle. rsp_inst and all decoded fields are registered and hold their value until the next response on that channel.
- Misaligned (fetch_addr[1:0] != 0):
  - Granted normally; response has rsp_err=1 and rsp_inst=0x00000013 (NOP).
  - Decoded fields are those of the NOP: rd=0, rs1=0, imm=0.
- Immediate decode, by opcode [6:0]:
  - I (0000011, 0010011, 1100111, 1110011): sext(inst[31:20])
  - S (0100011)
  - B (1100011): bit0=0
  - U (0110111, 0010111): inst[31:12]<<12
  - J (1101111): bit0=0
  - any other opcode: 0
- rs1/rs2/rd are always the raw fields, regardless of instruction type.
- Reset mid-LOAD: returns to SERVE with load_ready=0; words already written are retained. Any in-flight response is discarded (rsp_valid=0).
- load_mode rise while a grant's response is pending: the response still completes in the following cycle.

Decomposition:
- Package imem_pkg holds:
  - opcode localparams and the NOP constant
  - imem_state_e {SERVE, LOAD} and imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
  - pure functions imm_type_of(opcode) and decode_imm(inst)
- Sub-module rr_arbiter (parameter N): req, advance, gnt, pointer register with async reset. It is reusable for the data-memory successor.

Test Plan:
- Load, then single fetch: write 0xFFF00093 at 0x000 and exit LOAD; core0 fetches 0x000. Expect gnt[0] same cycle; next cycle rsp_valid[0]=1, inst=0xFFF00093, rd=1, rs1=0, imm=0xFFFFFFFF.
- Decode coverage: load 0x00112223 @0x004 and 0x123452B7 @0x008.
  - Fetch 0x004: rs1=2, rs2=1, imm=0x00000004.
  - Fetch 0x008: rd=5, imm=0x12345000.
- Fairness: all 4 cores request continuously from reset. Grants go 0,1,2,3,0 over five consecutive cycles; each core gets exactly one rsp_valid per 4 cycles.
- Misaligned: core2 fetches 0x006. Expect rsp_valid[2]=1, rsp_err[2]=1, inst=0x00000013, imm=0.
- Load priority: load_mode and fetch_req[1] rise in the same cycle. Expect gnt=0 for the whole LOAD period and gnt[1] in the first SERVE cycle after load_mode falls; the response returns the newly loaded word.
- Reset mid-load: write 0x00000033 @0x010, pulse rst_n low before load_mode falls. After reset, load_ready=0 and rsp_valid=0; a fetch of 0x010 returns 0x00000033.
